// File: rtl/ak4619_tdm_if.sv
// rtl/ak4619_tdm_if.sv - parallel sample exchange bus between DSP core and the AK4619 TDM master
//
// Signals:
//   dac_samples    N_CH*W  DAC words, slot s at [s*W +: W], driven by the DSP core
//   adc_samples    N_CH*W  ADC words, same packing, driven by the TDM master
//   sample_strobe  1       one-cycle pulse at each frame boundary
// Modports:
//   master  DSP-core side (drives dac_samples)
//   slave   TDM master side (drives adc_samples and sample_strobe)
interface ak4619_tdm_if #(
    parameter int W    = 16,
    parameter int N_CH = 4
);
    logic [N_CH*W-1:0] dac_samples;
    logic [N_CH*W-1:0] adc_samples;
    logic              sample_strobe;

    modport master (
        output dac_samples,
        input  adc_samples,
        input  sample_strobe
    );

    modport slave (
        input  dac_samples,
        output adc_samples,
        output sample_strobe
    );
endinterface

// File: rtl/ak4619_tdm.sv
// rtl/ak4619_tdm.sv - TDM serial-audio master for the AK4619 codec (MCLK/BICK/LRCK, SDIN1 out, SDOUT1 in)
//
// Parameters: W (sample bits), N_CH (slots per frame), SLOT_BITS (BICK periods per slot, >= W),
//             BICK_DIV (clk cycles per BICK half-period).
// Ports:
//   clk     in   system clock, also forwarded as mclk
//   rst     in   synchronous active-high reset
//   smp     slave modport of ak4619_tdm_if: dac_samples in, adc_samples/sample_strobe out
//   pdn     out  codec power-down, active low
//   mclk    out  = clk
//   bick    out  bit clock, registered
//   lrck    out  frame sync, high for the first half of the frame, registered
//   sdin1   out  serial DAC data, MSB-justified, registered
//   sdout1  in   serial ADC data, sampled on the BICK rising edge
// Build option: AK4619_LOOPBACK_EN - each frame replays the previous frame's ADC words on sdin1
//               instead of dac_samples.
module ak4619_tdm #(
    parameter int W         = 16,
    parameter int N_CH      = 4,
    parameter int SLOT_BITS = 32,
    parameter int BICK_DIV  = 2
) (
    input  logic         clk,
    input  logic         rst,
    ak4619_tdm_if.slave  smp,
    output logic         pdn,
    output logic         mclk,
    output logic         bick,
    output logic         lrck,
    output logic         sdin1,
    input  logic         sdout1
);
    localparam int FRAME = N_CH * SLOT_BITS;
    localparam int DIVN  = 2 * BICK_DIV;
    localparam int DW    = $clog2(DIVN);
    localparam int BW    = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int SW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int JW    = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam int IW    = (W > 1) ? $clog2(W) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIVN - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BICK_DIV);
    localparam logic [DW-1:0] RISE_PRE = DW'(BICK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME - 1);
    localparam logic [BW-1:0] BIT_HALF = BW'(FRAME / 2);
    localparam logic [JW-1:0] BIS_LAST = JW'(SLOT_BITS - 1);
    localparam logic [JW:0]   W_J      = (JW + 1)'(W);
    localparam logic [IW-1:0] MSB_I    = IW'(W - 1);

    logic                      pdn_q, pdn_d;
    logic [DW-1:0]             div_q, div_d;
    logic [BW-1:0]             bit_q, bit_d;
    logic [SW-1:0]             slot_q, slot_d;
    logic [JW-1:0]             bis_q, bis_d;
    logic                      bick_q, bick_d;
    logic                      lrck_q, lrck_d;
    logic                      sdin1_q, sdin1_d;
    logic                      strobe_q, strobe_d;
    logic [N_CH-1:0][W-1:0]    dac_hold_q, dac_hold_d;
    logic [N_CH-1:0][W-1:0]    adc_shift_q, adc_shift_d;
    logic [N_CH-1:0][W-1:0]    adc_out_q, adc_out_d;
    logic [N_CH-1:0][W-1:0]    load_src;
    logic [W-1:0]              tx_word;

`ifdef AK4619_LOOPBACK_EN
    assign load_src = adc_shift_q;
`else
    assign load_src = smp.dac_samples;
`endif

    always_comb begin
        pdn_d       = 1'b1;
        div_d       = div_q;
        bit_d       = bit_q;
        slot_d      = slot_q;
        bis_d       = bis_q;
        strobe_d    = 1'b0;
        dac_hold_d  = dac_hold_q;
        adc_shift_d = adc_shift_q;
        adc_out_d   = adc_out_q;

        if (!pdn_q) begin
            // First cycle out of reset: take the initial DAC words, counters stay parked at bit 0.
            dac_hold_d = load_src;
        end else begin
            if (div_q == DIV_LAST) begin
                // BICK falling edge: step to the next bit.
                div_d = '0;
                if (bit_q == BIT_LAST) begin
                    bit_d      = '0;
                    slot_d     = '0;
                    bis_d      = '0;
                    strobe_d   = 1'b1;
                    adc_out_d  = adc_shift_q;
                    dac_hold_d = load_src;
                end else begin
                    bit_d = bit_q + 1'b1;
                    if (bis_q == BIS_LAST) begin
                        bis_d  = '0;
                        slot_d = slot_q + 1'b1;
                    end else begin
                        bis_d = bis_q + 1'b1;
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end

            // BICK rising edge: capture the codec bit for the current slot while inside the word.
            if ((div_q == RISE_PRE) && ({1'b0, bis_q} < W_J)) begin
                adc_shift_d[slot_q] = W'({adc_shift_q[slot_q], sdout1});
            end
        end

        // Pin outputs are registered from next-state counters so they move on the same edge.
        bick_d  = (div_d >= DIV_HALF);
        lrck_d  = (bit_d < BIT_HALF);
        tx_word = dac_hold_d[slot_d];
        sdin1_d = ({1'b0, bis_d} < W_J) ? tx_word[MSB_I - IW'(bis_d)] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pdn_q       <= 1'b0;
            div_q       <= '0;
            bit_q       <= '0;
            slot_q      <= '0;
            bis_q       <= '0;
            bick_q      <= 1'b0;
            lrck_q      <= 1'b0;
            sdin1_q     <= 1'b0;
            strobe_q    <= 1'b0;
            dac_hold_q  <= '0;
            adc_shift_q <= '0;
            adc_out_q   <= '0;
        end else begin
            pdn_q       <= pdn_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            slot_q      <= slot_d;
            bis_q       <= bis_d;
            bick_q      <= bick_d;
            lrck_q      <= lrck_d;
            sdin1_q     <= sdin1_d;
            strobe_q    <= strobe_d;
            dac_hold_q  <= dac_hold_d;
            adc_shift_q <= adc_shift_d;
            adc_out_q   <= adc_out_d;
        end
    end

    assign pdn               = pdn_q;
    assign mclk              = clk;
    assign bick              = bick_q;
    assign lrck              = lrck_q;
    assign sdin1             = sdin1_q;
    assign smp.sample_strobe = strobe_q;
    assign smp.adc_samples   = adc_out_q;
endmodule

// File: tb/tb_ak4619_tdm.sv
// tb/tb_ak4619_tdm.sv - self-checking bench for ak4619_tdm (default and 2ch/24bit/BICK_DIV=1 instances)
module tb_ak4619_tdm;
    localparam int AW = 16, AN = 4, ASB = 32, ABD = 2;
    localparam int AFC = AN * ASB * 2 * ABD;
    localparam int BWD = 24, BN = 2, BSB = 32, BBD = 1;
    localparam int BFC = BN * BSB * 2 * BBD;
`ifdef AK4619_LOOPBACK_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif
    localparam logic [63:0] DAC_A = 64'h8001_00FF_1234_A5A5;
    localparam logic [47:0] DAC_B = {24'h123456, 24'hC00003};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1;
    logic sdout_a = 1'b0, sdout_b = 1'b0;
    logic pdn_a, mclk_a, bick_a, lrck_a, sdin_a;
    logic pdn_b, mclk_b, bick_b, lrck_b, sdin_b;

    ak4619_tdm_if #(.W(AW), .N_CH(AN)) if_a ();
    ak4619_tdm_if #(.W(BWD), .N_CH(BN)) if_b ();

    ak4619_tdm #(.W(AW), .N_CH(AN), .SLOT_BITS(ASB), .BICK_DIV(ABD)) dut_a (
        .clk(clk), .rst(rst_a), .smp(if_a), .pdn(pdn_a), .mclk(mclk_a),
        .bick(bick_a), .lrck(lrck_a), .sdin1(sdin_a), .sdout1(sdout_a));

    ak4619_tdm #(.W(BWD), .N_CH(BN), .SLOT_BITS(BSB), .BICK_DIV(BBD)) dut_b (
        .clk(clk), .rst(rst_b), .smp(if_b), .pdn(pdn_b), .mclk(mclk_b),
        .bick(bick_b), .lrck(lrck_b), .sdin1(sdin_b), .sdout1(sdout_b));

    int checks = 0, errors = 0, cyc = 0;
    int t_a = -1, t_b = -1;
    int pdn_rise_a[$], strobe_a[$], lrck_rise_b[$];
    int first_bick_a = -1, lrck_hi_b = 0;
    logic pdn_a_prev = 1'b0, bick_a_prev = 1'b0, lrck_b_prev = 1'b0;
    logic [31:0] cap_a0 = '0, cap_a3 = '0, cap_a2 = '0, cap_b0 = '0;
    logic [63:0] adc_first_a = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Codec ADC words per frame; in loopback builds slot0 changes between frames.
    function automatic logic [63:0] codec_a(int f);
        logic [15:0] s0;
        s0 = LOOP ? ((f == 0) ? 16'h1357 : 16'h2468) : 16'h0000;
        return {16'h0000, 16'h8000, 16'h7FFF, s0};
    endfunction

    function automatic logic [63:0] codec_b(int f);
        return {16'h0000, 24'h3C5A96, 24'hC00003} ^ 64'(f * 0);
    endfunction

    // Words that must be on sdin1 during frame f.
    function automatic logic [63:0] hold_a(int f);
        if (LOOP) return (f == 0) ? 64'h0 : codec_a(f - 1);
        return DAC_A;
    endfunction

    function automatic logic [63:0] hold_b(int f);
        if (LOOP) return (f == 0) ? 64'h0 : codec_b(f - 1);
        return {16'h0000, DAC_B};
    endfunction

    function automatic int bit_idx(int t, int nch, int sb, int bd);
        return (t / (2 * bd)) % (nch * sb);
    endfunction

    // Serial bit at time t (cycles since pdn rose) for an MSB-justified word table.
    function automatic logic word_bit(int t, int w, int nch, int sb, int bd,
                                      logic [63:0] words, logic fill);
        int b, s, j;
        logic [63:0] sh;
        if (t < 0) return 1'b0;
        b = bit_idx(t, nch, sb, bd);
        s = b / sb;
        j = b % sb;
        if (j >= w) return fill;
        sh = words >> (s * w + w - 1 - j);
        return sh[0];
    endfunction

    // Time base and codec model: sdout launched just after the edge that starts each bit.
    always @(posedge clk) begin
        if (rst_a) t_a = -1; else t_a = t_a + 1;
        if (rst_b) t_b = -1; else t_b = t_b + 1;
        #1;
        sdout_a = word_bit(t_a, AW, AN, ASB, ABD, codec_a((t_a < 0) ? 0 : t_a / AFC), 1'b1);
        sdout_b = word_bit(t_b, BWD, BN, BSB, BBD, codec_b((t_b < 0) ? 0 : t_b / BFC), 1'b1);
    end

    // Per-cycle comparison against the model, plus event capture for literal checks.
    always @(negedge clk) begin
        int fa, fb, ba, bb;
        logic [63:0] adc_exp_a, adc_exp_b;
        cyc++;
        fa = (t_a < 0) ? 0 : t_a / AFC;
        fb = (t_b < 0) ? 0 : t_b / BFC;
        adc_exp_a = (t_a < AFC) ? 64'h0 : codec_a(fa - 1);
        adc_exp_b = (t_b < BFC) ? 64'h0 : codec_b(fb - 1);

        chk("a_pdn", pdn_a, t_a >= 0);
        chk("a_bick", bick_a, (t_a >= 0) && ((t_a % (2 * ABD)) >= ABD));
        chk("a_lrck", lrck_a, (t_a >= 0) && (bit_idx(t_a, AN, ASB, ABD) < AN * ASB / 2));
        chk("a_sdin1", sdin_a, word_bit(t_a, AW, AN, ASB, ABD, hold_a(fa), 1'b0));
        chk("a_strobe", if_a.sample_strobe, (t_a > 0) && ((t_a % AFC) == 0));
        chk("a_adc", if_a.adc_samples, adc_exp_a);
        chk("b_pdn", pdn_b, t_b >= 0);
        chk("b_bick", bick_b, (t_b >= 0) && ((t_b % (2 * BBD)) >= BBD));
        chk("b_lrck", lrck_b, (t_b >= 0) && (bit_idx(t_b, BN, BSB, BBD) < BN * BSB / 2));
        chk("b_sdin1", sdin_b, word_bit(t_b, BWD, BN, BSB, BBD, hold_b(fb), 1'b0));
        chk("b_strobe", if_b.sample_strobe, (t_b > 0) && ((t_b % BFC) == 0));
        chk("b_adc", {16'h0, if_b.adc_samples}, adc_exp_b);

        if (pdn_a && !pdn_a_prev) pdn_rise_a.push_back(cyc);
        if (bick_a && !bick_a_prev && first_bick_a < 0) first_bick_a = cyc;
        if (if_a.sample_strobe) strobe_a.push_back(cyc);
        if (lrck_b && !lrck_b_prev) lrck_rise_b.push_back(cyc);
        if (t_b >= BFC && t_b < 2 * BFC && lrck_b) lrck_hi_b++;
        pdn_a_prev  = pdn_a;
        bick_a_prev = bick_a;
        lrck_b_prev = lrck_b;

        if (t_a == AFC) adc_first_a = if_a.adc_samples;
        if (t_a >= AFC && t_a < 2 * AFC && (t_a % (2 * ABD)) == 0) begin
            ba = (t_a - AFC) / (2 * ABD);
            if (ba < 32) cap_a0[31 - ba] = sdin_a;
            if (ba >= 96) cap_a3[127 - ba] = sdin_a;
        end
        if (t_a >= 2 * AFC && t_a < 2 * AFC + 128 && (t_a % (2 * ABD)) == 0) begin
            ba = (t_a - 2 * AFC) / (2 * ABD);
            cap_a2[31 - ba] = sdin_a;
        end
        if (t_b >= BFC && t_b < BFC + 64 && (t_b % (2 * BBD)) == 0) begin
            bb = (t_b - BFC) / (2 * BBD);
            cap_b0[31 - bb] = sdin_b;
        end
    end

    task automatic wait_ta(input int target, input string nm);
        int guard;
        guard = 0;
        while (t_a != target && guard < 6000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 6000) begin
            checks++;
            errors++;
            $display("FAIL %s: timed out waiting for t=%0d, at t=%0d", nm, target, t_a);
        end
    endtask

    initial begin
        if_a.dac_samples = DAC_A;
        if_b.dac_samples = DAC_B;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // One-cycle reset in the middle of frame 2, at bit 70.
        wait_ta(2 * AFC + 70 * 2 * ABD + 1, "wait_bit70");
        rst_a = 1'b1;
        @(negedge clk);
        chk("adc_after_reset", if_a.adc_samples, 64'h0);
        chk("strobes_before_reset", 64'(strobe_a.size()), 64'd2);
        rst_a = 1'b0;
        @(negedge clk);
        wait_ta(3 * AFC + 8, "wait_restart_run");

        chk("strobe_count", 64'(strobe_a.size()), 64'd5);
        chk("pdn_rise_count", 64'(pdn_rise_a.size()), 64'd2);
        if (strobe_a.size() >= 5 && pdn_rise_a.size() >= 2) begin
            chk("first_bick_delay", 64'(first_bick_a - pdn_rise_a[0]), 64'd2);
            chk("first_strobe", 64'(strobe_a[0] - pdn_rise_a[0]), 64'd512);
            chk("strobe_period", 64'(strobe_a[1] - strobe_a[0]), 64'd512);
            chk("restart_strobe", 64'(strobe_a[2] - pdn_rise_a[1]), 64'd512);
            chk("restart_period", 64'(strobe_a[4] - strobe_a[3]), 64'd512);
        end
        chk("adc_first_frame", adc_first_a,
            LOOP ? 64'h0000_8000_7FFF_1357 : 64'h0000_8000_7FFF_0000);
        chk("sdin_slot0_f1", {32'h0, cap_a0}, LOOP ? 64'h1357_0000 : 64'hA5A5_0000);
        chk("sdin_slot3_f1", {32'h0, cap_a3}, LOOP ? 64'h0000_0000 : 64'h8001_0000);
        chk("sdin_slot0_f2", {32'h0, cap_a2}, LOOP ? 64'h2468_0000 : 64'hA5A5_0000);
        chk("b_sdin_slot0", {32'h0, cap_b0}, 64'hC000_0300);
        chk("b_lrck_high", 64'(lrck_hi_b), 64'd64);
        if (lrck_rise_b.size() >= 2)
            chk("b_lrck_period", 64'(lrck_rise_b[1] - lrck_rise_b[0]), 64'd128);
        else
            chk("b_lrck_rises", 64'(lrck_rise_b.size()), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
